// File: rtl/synth_param_stager.sv
// Parameter staging between the UART register bank and the synth core.
// Registers control, samples duty on ticks, commits frequency after a settle window, ramps volume.
//
// Ports:
//   clk, rst (sync, active-high), sample_tick (audio-rate strobe)
//   reg_control/reg_freq_low/mid/high/reg_duty/reg_volume : raw register bytes
//   osc_en, gate, wave_en            : registered control bits
//   duty_out                         : duty, updated on sample_tick only
//   freq_word, freq_commit           : committed frequency and its load pulse
//   freq_pending                     : high while a frequency change is settling
//   volume_out                       : volume ramped toward its target
module synth_param_stager #(
  parameter int unsigned SETTLE_CYCLES = 20000,
  parameter int unsigned VOL_STEP      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_tick,
  input  logic [7:0]  reg_control,
  input  logic [7:0]  reg_freq_low,
  input  logic [7:0]  reg_freq_mid,
  input  logic [7:0]  reg_freq_high,
  input  logic [7:0]  reg_duty,
  input  logic [7:0]  reg_volume,
  output logic        osc_en,
  output logic        gate,
  output logic [2:0]  wave_en,
  output logic [7:0]  duty_out,
  output logic [23:0] freq_word,
  output logic        freq_commit,
  output logic        freq_pending,
  output logic [7:0]  volume_out
);

  localparam int unsigned CW = $clog2(SETTLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic {
    IDLE,
    SETTLING
  } state_t;

  state_t        state_q;
  logic          osc_en_q;
  logic          gate_q;
  logic [2:0]    wave_en_q;
  logic [7:0]    duty_q;
  logic [7:0]    duty_d;
  logic [23:0]   seen_q;
  logic [23:0]   word_q;
  logic [CW-1:0] cnt_q;
  logic          commit_q;
  logic          pend_q;
  logic [7:0]    vol_q;
  logic [7:0]    vol_d;

  logic [23:0] raw;
  logic        chg;
  logic [7:0]  tgt;
  logic [8:0]  up9;
  logic [8:0]  dn9;
  logic        unused_ctrl;

  assign raw = {reg_freq_high, reg_freq_mid, reg_freq_low};
  assign chg = (raw != seen_q);
  assign unused_ctrl = ^reg_control[7:5];

  always_ff @(posedge clk) begin
    if (rst) begin
      osc_en_q  <= 1'b0;
      gate_q    <= 1'b0;
      wave_en_q <= 3'b111;
    end else begin
      osc_en_q  <= reg_control[0];
      gate_q    <= reg_control[1];
      wave_en_q <= reg_control[4:2];
    end
  end

  always_comb begin
    duty_d = duty_q;
    if (sample_tick) duty_d = reg_duty;
  end

  // A change always wins over a terminal count, so a byte that
  // lands on the commit edge restarts the window instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      seen_q   <= '0;
      word_q   <= '0;
      cnt_q    <= '0;
      commit_q <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      commit_q <= 1'b0;
      if (chg) begin
        seen_q <= raw;
        cnt_q  <= '0;
        if (!osc_en_q) begin
          word_q   <= raw;
          commit_q <= 1'b1;
          state_q  <= IDLE;
          pend_q   <= 1'b0;
        end else begin
          state_q <= SETTLING;
          pend_q  <= 1'b1;
        end
      end else if (state_q == SETTLING) begin
        if (cnt_q == CNT_LAST) begin
          word_q   <= seen_q;
          commit_q <= 1'b1;
          state_q  <= IDLE;
          pend_q   <= 1'b0;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  // 9-bit sums expose overflow past 0xFF and borrow below 0.
  assign tgt = osc_en_q ? reg_volume : 8'h00;
  assign up9 = {1'b0, vol_q} + 9'(VOL_STEP);
  assign dn9 = {1'b0, vol_q} - 9'(VOL_STEP);

  always_comb begin
    vol_d = vol_q;
    if (sample_tick) begin
      if (vol_q < tgt) begin
        vol_d = (up9 > {1'b0, tgt}) ? tgt : up9[7:0];
      end else if (vol_q > tgt) begin
        vol_d = (dn9[8] || (dn9[7:0] < tgt)) ? tgt : dn9[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q <= 8'h80;
      vol_q  <= 8'h00;
    end else begin
      duty_q <= duty_d;
      vol_q  <= vol_d;
    end
  end

  assign osc_en       = osc_en_q;
  assign gate         = gate_q;
  assign wave_en      = wave_en_q;
  assign duty_out     = duty_q;
  assign freq_word    = word_q;
  assign freq_commit  = commit_q;
  assign freq_pending = pend_q;
  assign volume_out   = vol_q;

endmodule
